// File: rtl/pc_fetch_unit.sv
// MIPS32 program-counter / instruction-fetch stage: req/ack word fetch, hold-for-decode, redirect.
// Optional misaligned-target trap state enabled by defining PC_MISALIGN_TRAP_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic        trap,
  output logic [1:0]  dbg_state
);

`ifdef PC_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, TRAP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_seq, mux_l1, mux_out, next_pc;
  logic        redirect, load_instr, flush;

  // Next-PC chain: level 1 picks branch over sequential, level 2 lets jump win.
  assign pc_seq   = pc_q + 32'd4;
  assign mux_l1   = branch_taken ? branch_target : pc_seq;
  assign mux_out  = jump ? jump_target : mux_l1;
  assign redirect = jump | branch_taken;

`ifdef PC_MISALIGN_TRAP_EN
  logic misaligned;
  assign next_pc    = mux_out;
  assign misaligned = redirect & (mux_out[1:0] != 2'b00);
  assign trap       = (state_q == TRAP);
`else
  assign next_pc = mux_out & ~32'h3;
  assign trap    = 1'b0;
`endif

  assign imem_req  = rst_n & (state_q == FETCH);
  assign imem_addr = pc_q;
  assign pc_plus4  = instr_pc + 32'd4;
  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    load_instr = 1'b0;
    flush      = 1'b0;
    case (state_q)
      FETCH: begin
        // A redirect discards any word acked in the same cycle.
        if (redirect) begin
          pc_d = next_pc;
`ifdef PC_MISALIGN_TRAP_EN
          if (misaligned) state_d = TRAP;
`endif
        end else if (imem_ack) begin
          load_instr = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (redirect || !stall) begin
          pc_d    = next_pc;
          flush   = 1'b1;
          state_d = FETCH;
`ifdef PC_MISALIGN_TRAP_EN
          if (misaligned) state_d = TRAP;
`endif
        end
      end
`ifdef PC_MISALIGN_TRAP_EN
      TRAP: begin
        state_d = TRAP;
      end
`endif
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= 32'h0;
      instr_pc    <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (load_instr) begin
        instr       <= imem_rdata;
        instr_pc    <= pc_q;
        instr_valid <= 1'b1;
      end else if (flush) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: cycle-by-cycle vector table plus hand sequences for trap and mid-fetch reset.
module tb_pc_fetch_unit;
  localparam logic [31:0] RPC = 32'h0040_0000;
  localparam int EW = 131;

  logic        clk, rst_n, stall, branch_taken, jump, imem_ack;
  logic [31:0] branch_target, jump_target, imem_rdata;
  logic        imem_req, instr_valid, trap;
  logic [31:0] imem_addr, instr, instr_pc, pc_plus4;
  logic [1:0]  dbg_state;

  pc_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .pc_plus4(pc_plus4), .trap(trap), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst; logic stl; logic br; logic [31:0] bt; logic j; logic [31:0] jt;
    logic ack; logic [31:0] rd;
    logic ereq; logic [31:0] eaddr; logic evalid; logic [31:0] einstr; logic [31:0] eipc;
  } vec_t;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[21];

  function automatic vec_t mkv(logic rst, logic stl, logic br, logic [31:0] bt,
                               logic j, logic [31:0] jt, logic ack, logic [31:0] rd,
                               logic ereq, logic [31:0] eaddr, logic evalid,
                               logic [31:0] einstr, logic [31:0] eipc);
    vec_t v;
    v.rst = rst; v.stl = stl; v.br = br; v.bt = bt; v.j = j; v.jt = jt;
    v.ack = ack; v.rd = rd; v.ereq = ereq; v.eaddr = eaddr; v.evalid = evalid;
    v.einstr = einstr; v.eipc = eipc;
    return v;
  endfunction

  // scoreboard: pop the oldest expectation and compare with what the DUT shows now
  task automatic check_out(input string name);
    logic [EW-1:0] e, got;
    got = {imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus4, trap};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got %h, required an expectation but queue empty", name, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got req=%b addr=%h v=%b instr=%h ipc=%h pp4=%h trap=%b, required req=%b addr=%h v=%b instr=%h ipc=%h pp4=%h trap=%b",
                 name, got[130], got[129:98], got[97], got[96:65], got[64:33], got[32:1], got[0],
                 e[130], e[129:98], e[97], e[96:65], e[64:33], e[32:1], e[0]);
      end
    end
  endtask

  // driver: apply one cycle of inputs, record expectation, check after the edge
  task automatic apply(input vec_t v, input logic etrap, input string name);
    exp_q.push_back({v.ereq, v.eaddr, v.evalid, v.einstr, v.eipc, v.eipc + 32'd4, etrap});
    rst_n = v.rst; stall = v.stl; branch_taken = v.br; branch_target = v.bt;
    jump = v.j; jump_target = v.jt; imem_ack = v.ack; imem_rdata = v.rd;
    @(negedge clk);
    check_out(name);
  endtask

  logic [31:0] w[10];

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; imem_ack = 1'b0;
    branch_target = 32'h0; jump_target = 32'h0; imem_rdata = 32'h0;
    for (int i = 0; i < 10; i++) w[i] = $urandom_range(32'h7fff_ffff, 0) ^ (i << 28);

    //                rst stl br bt            j  jt            ack rd      | req addr          v  instr  ipc
    vecs[0]  = mkv(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'hBEEF, 0, RPC,           0, 32'h0, 32'h0);
    vecs[1]  = mkv(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,    1, RPC,           0, 32'h0, 32'h0);
    vecs[2]  = mkv(1, 0, 0, 32'h0,         0, 32'h0,         1, w[0],     0, RPC,           1, w[0],  RPC);
    vecs[3]  = mkv(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,    1, RPC+4,         0, w[0],  RPC);
    vecs[4]  = mkv(1, 0, 0, 32'h0,         0, 32'h0,         1, w[1],     0, RPC+4,         1, w[1],  RPC+4);
    vecs[5]  = mkv(1, 1, 0, 32'h0,         0, 32'h0,         1, 32'h5555, 0, RPC+4,         1, w[1],  RPC+4);
    vecs[6]  = mkv(1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,    0, RPC+4,         1, w[1],  RPC+4);
    vecs[7]  = mkv(1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,    0, RPC+4,         1, w[1],  RPC+4);
    vecs[8]  = mkv(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,    1, RPC+8,         0, w[1],  RPC+4);
    vecs[9]  = mkv(1, 0, 0, 32'h0,         0, 32'h0,         1, w[2],     0, RPC+8,         1, w[2],  RPC+8);
    vecs[10] = mkv(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,    1, RPC+12,        0, w[2],  RPC+8);
    vecs[11] = mkv(1, 0, 1, 32'h0000_2000, 1, 32'h0000_1000, 0, 32'h0,    1, 32'h0000_1000, 0, w[2],  RPC+8);
    vecs[12] = mkv(1, 0, 0, 32'h0,         0, 32'h0,         1, w[3],     0, 32'h0000_1000, 1, w[3],  32'h0000_1000);
    vecs[13] = mkv(1, 1, 1, 32'h0000_3000, 0, 32'h0,         0, 32'h0,    1, 32'h0000_3000, 0, w[3],  32'h0000_1000);
    vecs[14] = mkv(1, 0, 1, 32'h0000_0100, 0, 32'h0,         1, 32'hDEAD, 1, 32'h0000_0100, 0, w[3],  32'h0000_1000);
    vecs[15] = mkv(1, 0, 0, 32'h0,         0, 32'h0,         1, w[4],     0, 32'h0000_0100, 1, w[4],  32'h0000_0100);
    vecs[16] = mkv(1, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0,    1, 32'hFFFF_FFFC, 0, w[4],  32'h0000_0100);
    vecs[17] = mkv(1, 0, 0, 32'h0,         0, 32'h0,         1, w[5],     0, 32'hFFFF_FFFC, 1, w[5],  32'hFFFF_FFFC);
    vecs[18] = mkv(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,    1, 32'h0,         0, w[5],  32'hFFFF_FFFC);
    vecs[19] = mkv(1, 0, 0, 32'h0,         0, 32'h0,         1, w[6],     0, 32'h0,         1, w[6],  32'h0);
    vecs[20] = mkv(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,    1, 32'h4,         0, w[6],  32'h0);

    repeat (2) @(negedge clk);
    for (int i = 0; i < 21; i++) apply(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // misaligned jump target, then acked data and an aligned redirect
`ifdef PC_MISALIGN_TRAP_EN
    apply(mkv(1, 0, 0, 32'h0, 1, 32'h0000_1002, 0, 32'h0, 0, 32'h0000_1002, 0, w[6], 32'h0), 1'b1, "trap_enter");
    apply(mkv(1, 0, 0, 32'h0, 0, 32'h0,         1, w[7],  0, 32'h0000_1002, 0, w[6], 32'h0), 1'b1, "trap_hold_ack");
    apply(mkv(1, 0, 0, 32'h0, 1, 32'h0000_2000, 0, 32'h0, 0, 32'h0000_1002, 0, w[6], 32'h0), 1'b1, "trap_hold_jump");
`else
    apply(mkv(1, 0, 0, 32'h0, 1, 32'h0000_1002, 0, 32'h0, 1, 32'h0000_1000, 0, w[6], 32'h0), 1'b0, "mask_target");
    apply(mkv(1, 0, 0, 32'h0, 0, 32'h0,         1, w[7],  0, 32'h0000_1000, 1, w[7], 32'h0000_1000), 1'b0, "mask_fetch");
    apply(mkv(1, 0, 0, 32'h0, 1, 32'h0000_2000, 0, 32'h0, 1, 32'h0000_2000, 0, w[7], 32'h0000_1000), 1'b0, "hold_jump");
`endif

    // reset while a fetch is outstanding, with an ack arriving during reset
    apply(mkv(0, 0, 0, 32'h0, 0, 32'h0, 1, 32'hBEEF, 0, RPC, 0, 32'h0, 32'h0), 1'b0, "midreset");
    apply(mkv(1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0,    1, RPC, 0, 32'h0, 32'h0), 1'b0, "post_reset_req");
    apply(mkv(1, 0, 0, 32'h0, 0, 32'h0, 1, w[8],     0, RPC, 1, w[8],  RPC),   1'b0, "post_reset_fetch");

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d leftover, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion, required finish");
    $fatal(1, "timeout");
  end
endmodule
